// File: rtl/sdpb_dbuf_pkg.sv
// Shared types and elaboration-time helpers for the ping-pong double buffer.
package sdpb_dbuf_pkg;

    typedef enum logic [0:0] {
        StFill = 1'b0,
        StHold = 1'b1
    } state_e;

    function automatic int unsigned width_ratio(input int unsigned a, input int unsigned b);
        return (a > b) ? a / b : b / a;
    endfunction

    function automatic int unsigned rd_depth(input int unsigned wr_depth,
                                             input int unsigned wr_width,
                                             input int unsigned rd_width);
        return wr_depth * wr_width / rd_width;
    endfunction

    // Position of a narrow word inside the wide RAM line that contains it.
    function automatic int unsigned lane_index(input int unsigned addr, input int unsigned per);
        return addr % per;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int unsigned wr_width, input int unsigned rd_width,
                                     input int unsigned wr_depth, input int unsigned latency);
        return (wr_width != 0) && (rd_width != 0) &&
               (wr_width % 8 == 0) && (rd_width % 8 == 0) &&
               ((wr_width % rd_width == 0) || (rd_width % wr_width == 0)) &&
               is_pow2(width_ratio(wr_width, rd_width)) && is_pow2(wr_depth) &&
               ((latency == 1) || (latency == 2));
    endfunction

endpackage

// File: rtl/sdpb_bank.sv
// One asymmetric-width simple dual-port RAM bank with byte enables and a registered read port.
module sdpb_bank
    import sdpb_dbuf_pkg::*;
#(
    parameter int unsigned WR_WIDTH = 32,
    parameter int unsigned RD_WIDTH = 16,
    parameter int unsigned WR_DEPTH = 512,
    localparam int unsigned WA = $clog2(WR_DEPTH),
    localparam int unsigned RA = $clog2(rd_depth(WR_DEPTH, WR_WIDTH, RD_WIDTH))
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [WA-1:0]         waddr,
    input  logic [WR_WIDTH-1:0]   wdata,
    input  logic [WR_WIDTH/8-1:0] wbe,
    input  logic                  re,
    input  logic [RA-1:0]         raddr,
    output logic [RD_WIDTH-1:0]   rdata
);

    // Storage is organised in lines of the wider port; the narrow port selects a lane.
    localparam int unsigned LINE_W     = (WR_WIDTH > RD_WIDTH) ? WR_WIDTH : RD_WIDTH;
    localparam int unsigned LINE_BYTES = LINE_W / 8;
    localparam int unsigned LINES      = WR_DEPTH * WR_WIDTH / LINE_W;
    localparam int unsigned LA         = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned WR_PER     = LINE_W / WR_WIDTH;
    localparam int unsigned RD_PER     = LINE_W / RD_WIDTH;
    localparam int unsigned WB         = WR_WIDTH / 8;
    localparam int unsigned RB         = RD_WIDTH / 8;
    localparam int unsigned WLB        = (WR_PER > 1) ? $clog2(WR_PER) : 1;
    localparam int unsigned RLB        = (RD_PER > 1) ? $clog2(RD_PER) : 1;

    logic [LINE_BYTES-1:0][7:0] mem [LINES];
    logic [LA-1:0]              wline, rline;
    logic [WLB-1:0]             wlane;
    logic [RLB-1:0]             rlane;

    assign wline = LA'(32'(waddr) / WR_PER);
    assign wlane = WLB'(lane_index(32'(waddr), WR_PER));
    assign rline = LA'(32'(raddr) / RD_PER);
    assign rlane = RLB'(lane_index(32'(raddr), RD_PER));

    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < WR_PER; l++) begin
                for (int k = 0; k < WB; k++) begin
                    if ((wlane == WLB'(l)) && wbe[k]) begin
                        mem[wline][l * WB + k] <= wdata[8 * k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (re) begin
            for (int l = 0; l < RD_PER; l++) begin
                if (rlane == RLB'(l)) begin
                    rdata <= mem[rline][l * RB +: RB];
                end
            end
        end
    end

endmodule

// File: rtl/sdpb_dbuf.sv
// Ping-pong frame buffer: writer fills the back bank, reader drains the front, commit/release swaps.
module sdpb_dbuf
    import sdpb_dbuf_pkg::*;
#(
    parameter int unsigned WR_WIDTH     = 32,
    parameter int unsigned RD_WIDTH     = 16,
    parameter int unsigned WR_DEPTH     = 512,
    parameter int unsigned READ_LATENCY = 1,
    localparam int unsigned RD_DEPTH = rd_depth(WR_DEPTH, WR_WIDTH, RD_WIDTH),
    localparam int unsigned WA       = $clog2(WR_DEPTH),
    localparam int unsigned RA       = $clog2(RD_DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [WA-1:0]         wr_addr,
    input  logic [WR_WIDTH-1:0]   wr_data,
    input  logic [WR_WIDTH/8-1:0] wr_be,
    output logic                  wr_ready,
    input  logic                  wr_commit,
    input  logic                  rd_en,
    input  logic [RA-1:0]         rd_addr,
    output logic [RD_WIDTH-1:0]   rd_data,
    output logic                  rd_valid,
    input  logic                  rd_release,
    output logic                  front_valid,
    output logic                  front_bank,
    output logic                  swap_pulse,
    output logic [15:0]           drop_cnt
);

    if (!params_ok(WR_WIDTH, RD_WIDTH, WR_DEPTH, READ_LATENCY)) begin : g_bad_params
        $error("sdpb_dbuf: unsupported parameter set");
    end

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        front_q, front_d;
    logic        fvalid_q, fvalid_d;
    logic        swap_q, swap_now, commit_req;
    logic [15:0] drop_q, drop_d;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        front_d    = front_q;
        fvalid_d   = fvalid_q;
        drop_d     = drop_q;
        commit_req = 1'b0;
        unique case (state_q)
            StFill: commit_req = wr_commit;
            StHold: begin
                commit_req = 1'b1;
                if (wr_en && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
            end
            default: ;
        endcase
        swap_now = commit_req && (!busy_q || rd_release);
        if (swap_now) begin
            front_d  = ~front_q;
            fvalid_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = StFill;
        end else begin
            if (commit_req) state_d = StHold;
            if (rd_release) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StFill;
            busy_q   <= 1'b0;
            front_q  <= 1'b0;
            fvalid_q <= 1'b0;
            swap_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            front_q  <= front_d;
            fvalid_q <= fvalid_d;
            swap_q   <= swap_now;
            drop_q   <= drop_d;
        end
    end

    assign wr_ready    = (state_q == StFill);
    assign front_valid = fvalid_q;
    assign front_bank  = front_q;
    assign swap_pulse  = swap_q;
    assign drop_cnt    = drop_q;

    // Writes go to the back bank, reads to the front; the two never collide.
    logic [1:0]          bank_we, bank_re;
    logic [RD_WIDTH-1:0] bank_rdata [2];

    assign bank_we = (wr_en && wr_ready && resetn) ? (front_q ? 2'b01 : 2'b10) : 2'b00;
    assign bank_re = rd_en ? (front_q ? 2'b10 : 2'b01) : 2'b00;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        sdpb_bank #(
            .WR_WIDTH (WR_WIDTH),
            .RD_WIDTH (RD_WIDTH),
            .WR_DEPTH (WR_DEPTH)
        ) u_bank (
            .clk    (clk),
            .resetn (resetn),
            .we     (bank_we[g]),
            .waddr  (wr_addr),
            .wdata  (wr_data),
            .wbe    (wr_be),
            .re     (bank_re[g]),
            .raddr  (rd_addr),
            .rdata  (bank_rdata[g])
        );
    end

    // Bank select travels with the read so in-flight reads survive a swap.
    logic                sel_q, valid1_q;
    logic [RD_WIDTH-1:0] bank_out;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q    <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= rd_en;
            if (rd_en) sel_q <= front_q;
        end
    end

    assign bank_out = sel_q ? bank_rdata[1] : bank_rdata[0];

    if (READ_LATENCY == 2) begin : g_oreg
        logic [RD_WIDTH-1:0] data_q;
        logic                valid_q;
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid1_q;
                if (valid1_q) data_q <= bank_out;
            end
        end
        assign rd_data  = data_q;
        assign rd_valid = valid_q;
    end else begin : g_noreg
        assign rd_data  = bank_out;
        assign rd_valid = valid1_q;
    end

endmodule

// File: tb/tb_sdpb_dbuf.sv
// Drives a latency-1 and a latency-2 instance with shared stimulus against a byte-level frame model.
module tb_sdpb_dbuf;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        wr_en = 1'b0, wr_commit = 1'b0, rd_en = 1'b0, rd_release = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = 4'hF;
    logic [9:0]  rd_addr = '0;

    // Index 0: READ_LATENCY=1 instance, index 1: READ_LATENCY=2 instance.
    logic [15:0] rd_data [2];
    logic [15:0] drop_cnt [2];
    logic        rd_valid [2];
    logic        wr_ready [2];
    logic        front_valid [2];
    logic        front_bank [2];
    logic        swap_pulse [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sdpb_dbuf #(.WR_WIDTH(32), .RD_WIDTH(16), .WR_DEPTH(512), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .wr_ready(wr_ready[0]), .wr_commit(wr_commit), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .rd_release(rd_release), .front_valid(front_valid[0]), .front_bank(front_bank[0]),
        .swap_pulse(swap_pulse[0]), .drop_cnt(drop_cnt[0])
    );

    sdpb_dbuf #(.WR_WIDTH(32), .RD_WIDTH(16), .WR_DEPTH(512), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .wr_ready(wr_ready[1]), .wr_commit(wr_commit), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .rd_release(rd_release), .front_valid(front_valid[1]), .front_bank(front_bank[1]),
        .swap_pulse(swap_pulse[1]), .drop_cnt(drop_cnt[1])
    );

    // Reference model: byte images of both banks plus frame-ownership flags.
    logic [7:0]  m_mem [2][2048];
    bit          m_known [2][2048];
    bit          m_front, m_valid, m_busy, m_hold, m_swap;
    int          m_drops;
    bit          pv [2];
    bit          pk [2];
    logic [15:0] pd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_front = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_hold = 1'b0; m_swap = 1'b0;
        m_drops = 0;
        for (int s = 0; s < 2; s++) begin
            pv[s] = 1'b0; pk[s] = 1'b0; pd[s] = '0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] nd;
        bit          nk;
        bit          bk;
        int          idx;
        if (!resetn) begin
            model_reset();
            return;
        end
        nk = m_valid;
        for (int b = 0; b < 2; b++) begin
            idx = int'(rd_addr) * 2 + b;
            nd[8 * b +: 8] = m_mem[m_front][idx];
            nk = nk && m_known[m_front][idx];
        end
        pv[1] = pv[0]; pk[1] = pk[0]; pd[1] = pd[0];
        pv[0] = rd_en; pk[0] = nk && rd_en; pd[0] = nd;
        bk = ~m_front;
        if (wr_en) begin
            if (m_hold) begin
                if (m_drops < 65535) m_drops++;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (wr_be[k]) begin
                        idx = int'(wr_addr) * 4 + k;
                        m_mem[bk][idx] = wr_data[8 * k +: 8];
                        m_known[bk][idx] = 1'b1;
                    end
                end
            end
        end
        if ((m_hold || wr_commit) && (!m_busy || rd_release)) begin
            m_front = ~m_front; m_valid = 1'b1; m_busy = 1'b1; m_hold = 1'b0; m_swap = 1'b1;
        end else begin
            m_swap = 1'b0;
            if (wr_commit) m_hold = 1'b1;
            if (rd_release) m_busy = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("wr_ready[%0d]", d), 32'(wr_ready[d]), 32'(!m_hold));
            chk($sformatf("front_bank[%0d]", d), 32'(front_bank[d]), 32'(m_front));
            chk($sformatf("front_valid[%0d]", d), 32'(front_valid[d]), 32'(m_valid));
            chk($sformatf("swap_pulse[%0d]", d), 32'(swap_pulse[d]), 32'(m_swap));
            chk($sformatf("drop_cnt[%0d]", d), 32'(drop_cnt[d]), 32'(m_drops));
            chk($sformatf("rd_valid[%0d]", d), 32'(rd_valid[d]), 32'(pv[d]));
            if (pv[d] && pk[d]) chk($sformatf("rd_data[%0d]", d), 32'(rd_data[d]), 32'(pd[d]));
            if (!resetn) chk($sformatf("rd_data_rst[%0d]", d), 32'(rd_data[d]), 32'h0);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0; wr_be = 4'hF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 2048; i++) m_known[s][i] = 1'b0;
        model_reset();

        // Reset held with strobes toggling.
        #2 resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = (i % 2) == 0; rd_en = (i % 2) == 1; wr_addr = 9'(i); wr_data = 32'hA5A5_0000;
            tick();
        end
        set_idle();
        resetn = 1'b1;
        tick();

        // Asymmetric read: one 32-bit word seen as two little-endian 16-bit words.
        wr_en = 1'b1; wr_addr = 9'd3; wr_data = 32'hDDCC_BBAA;
        tick();
        set_idle(); wr_commit = 1'b1;
        tick();
        chk("asym_swap_pulse", 32'(swap_pulse[0]), 32'h1);
        chk("asym_front_bank", 32'(front_bank[1]), 32'h1);
        set_idle(); rd_en = 1'b1; rd_addr = 10'd6;
        tick();
        chk("asym_l1_lo", 32'(rd_data[0]), 32'hBBAA);
        rd_addr = 10'd7;
        tick();
        chk("asym_l1_hi", 32'(rd_data[0]), 32'hDDCC);
        chk("asym_l2_lo", 32'(rd_data[1]), 32'hBBAA);
        set_idle();
        tick();
        chk("asym_l2_hi", 32'(rd_data[1]), 32'hDDCC);

        // Byte enables, then commit while the reader is busy and drop writes in HOLD.
        wr_en = 1'b1; wr_addr = 9'd5; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_data = 32'h1122_3344; wr_be = 4'b0101;
        tick();
        set_idle(); wr_commit = 1'b1;
        tick();
        chk("hold_wr_ready", 32'(wr_ready[0]), 32'h0);
        set_idle(); wr_en = 1'b1; wr_addr = 9'd5; wr_data = 32'h0;
        repeat (5) tick();
        chk("hold_drop5", 32'(drop_cnt[0]), 32'd5);
        set_idle(); rd_release = 1'b1;
        tick();
        chk("rel_swap_pulse", 32'(swap_pulse[0]), 32'h1);
        chk("rel_wr_ready", 32'(wr_ready[0]), 32'h1);
        chk("rel_front_bank", 32'(front_bank[0]), 32'h0);
        set_idle(); rd_en = 1'b1; rd_addr = 10'd10;
        tick();
        chk("be_lo", 32'(rd_data[0]), 32'hFF44);
        rd_addr = 10'd11;
        tick();
        chk("be_hi", 32'(rd_data[0]), 32'hFF22);
        set_idle();
        tick();

        // Write, commit and release in one cycle.
        wr_en = 1'b1; wr_addr = 9'd3; wr_data = 32'h5566_7788; wr_commit = 1'b1; rd_release = 1'b1;
        tick();
        chk("sim_swap_pulse", 32'(swap_pulse[0]), 32'h1);
        chk("sim_front_bank", 32'(front_bank[0]), 32'h1);
        set_idle(); rd_en = 1'b1; rd_addr = 10'd6;
        tick();
        chk("sim_single_pulse", 32'(swap_pulse[0]), 32'h0);
        chk("sim_front_once", 32'(front_bank[0]), 32'h1);
        chk("sim_data", 32'(rd_data[0]), 32'h7788);
        set_idle();
        tick();

        // Reset during HOLD with reads in flight.
        wr_commit = 1'b1;
        tick();
        set_idle(); rd_en = 1'b1; rd_addr = 10'd7;
        tick();
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid1", 32'(rd_valid[0]), 32'h0);
        chk("mid_rst_valid2", 32'(rd_valid[1]), 32'h0);
        chk("mid_rst_wr_ready", 32'(wr_ready[0]), 32'h1);
        model_reset();
        set_idle();
        repeat (2) tick();
        resetn = 1'b1;
        wr_commit = 1'b1;
        tick();
        chk("mid_rst_front", 32'(front_bank[0]), 32'h1);
        set_idle(); rd_en = 1'b1; rd_addr = 10'd6;
        tick();
        chk("mid_rst_retained", 32'(rd_data[0]), 32'h7788);
        set_idle();
        tick();

        // Randomized traffic on a small address window.
        for (int i = 0; i < 400; i++) begin
            resetn     = ($urandom_range(0, 99) != 0);
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 9'($urandom_range(0, 7));
            wr_data    = $urandom;
            wr_be      = 4'($urandom);
            wr_commit  = ($urandom_range(0, 7) == 0);
            rd_en      = 1'($urandom_range(0, 1));
            rd_addr    = 10'($urandom_range(0, 15));
            rd_release = ($urandom_range(0, 5) == 0);
            tick();
        end
        resetn = 1'b1;
        set_idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
